paddle_input_conditioner: RTL and testbench
===========================================

Name: paddle_input_conditioner

Overview:
- Two-channel switch conditioner that sits directly upstream of the pong top level and drives its incdec1/incdec2 inputs.
- Each channel synchronizes a raw board switch and debounces it with a counter FSM.
- Each channel exposes a debounced level, single-cycle edge pulses, and a frame-aligned level that changes only on refr_tick.
- Paddle direction therefore never changes mid-frame.

Parameters:
- DB_COUNT, 1_000_000, clk cycles an input must stay stable before it is accepted (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20, counter width; must satisfy 2^CNT_W > DB_COUNT.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- refr_tick  input  1  one-cycle 60 Hz frame strobe (from clk_60Hz)
- sw_raw  input  2  raw switches; bit0 = player 1, bit1 = player 2; asynchronous to clk
- db_level  output  2  debounced levels
- db_rise  output  2  one-cycle pulse when db_level goes 0->1
- db_fall  output  2  one-cycle pulse when db_level goes 1->0
- incdec  output  2  frame-aligned level; bit0 -> incdec1, bit1 -> incdec2

Behaviour:
- Reset: rst=0 clears everything asynchronously, regardless of clk.
  - Synchronizer flops, counters, db_level, db_rise, db_fall and incdec all go to 0.
  - FSM goes to S_LO.
  - Reset is honoured mid-debounce; any partial count is discarded.
- Synchronizer: two flops per bit. s = second flop output. Raw-to-s latency is 2 cycles.
- Per-channel FSM:
  - S_LO: db_level=0. If s=1: go to S_WHI, counter=1.
  - S_WHI: if s=0: back to S_LO, counter=0, no output change.
    - Else if counter==DB_COUNT-1: go to S_HI, db_level<=1, db_rise pulses that cycle.
    - Else counter++.
  - S_HI: db_level=1. If s=0: go to S_WLO, counter=1.
  - S_WLO: if s=1: back to S_HI, counter=0.
    - Else if counter==DB_COUNT-1: go to S_LO, db_level<=0, db_fall pulses.
    - Else counter++.
- Debounce latency: a clean edge on sw_raw shows on db_level exactly 2+DB_COUNT cycles later.
  - The edge pulse is asserted in the same cycle db_level first takes its new value.
- Glitches: any glitch shorter than DB_COUNT consecutive stable samples produces no db_level change and no pulse.
- Counter:
  - Saturates by construction (it can never exceed DB_COUNT-1).
  - Zero whenever the FSM is in S_LO or S_HI.
  - Never wraps.
- db_rise and db_fall are never high in the same cycle for one channel. Each stays high exactly 1 cycle.
- Frame alignment:
  - incdec[i] <= db_level[i] only on a cycle where refr_tick=1; otherwise it holds.
  - If refr_tick and a db_level update occur in the same cycle, incdec takes the old (pre-update) db_level.
  - The new value is taken at the next refr_tick.
- Channels are fully independent. Simultaneous activity on both channels has no interaction.

Decomposition:
- Shared package holds:
  - FSM state encoding S_LO=2'd0, S_WHI=2'd1, S_HI=2'd2, S_WLO=2'd3.
  - Default DB_COUNT.
  - Simulation override constant DB_COUNT_SIM=8.
- One sub-module, debounce_channel: synchronizer, FSM, counter and edge pulses for 1 bit. It is instantiated twice.
- Frame-alignment registers stay in the parent.

Test Plan (DB_COUNT=8):
1. Reset/idle: hold rst=0 for 5 cycles with sw_raw=2'b11 -> all outputs 0. Release rst -> db_level[1:0]=2'b11 exactly 10 cycles later, with db_rise=2'b11 for 1 cycle and incdec still 0 until the next refr_tick.
2. Clean press: sw_raw[0] 0->1 at cycle t -> db_level[0]=1 and db_rise[0]=1 at t+10, db_rise[0]=0 at t+11. Then pulse refr_tick at t+20 -> incdec[0]=1 from t+21.
3. Bounce rejection: toggle sw_raw[0] 1,0,1,0 with 3-cycle periods, then settle at 0 -> no change on db_level[0], db_rise[0] or db_fall[0].
4. Boundary length: pulse sw_raw[1] high for 7 cycles -> ignored. Pulse it high for 8 cycles -> db_level[1]=1 for exactly 8 cycles, with one db_rise pulse and one db_fall pulse.
5. Coincidence: assert refr_tick in the same cycle db_level[0] rises -> incdec[0] stays 0 and becomes 1 only after the following refr_tick.
6. Mid-debounce reset: drive rst=0 at count 5 of a rising debounce -> outputs 0 immediately. After release with sw_raw still high, a full 10-cycle latency is required again.

Source files
------------

// File: rtl/paddle_input_conditioner_pkg.sv
// Shared types and constants for the two-channel paddle switch conditioner.
package paddle_input_conditioner_pkg;

    typedef enum logic [1:0] {
        StLo  = 2'd0,
        StWhi = 2'd1,
        StHi  = 2'd2,
        StWlo = 2'd3
    } db_state_e;

    localparam int unsigned DbCountDefault = 1_000_000;
    localparam int unsigned DbCountSim     = 8;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchronizer, counter-based debounce FSM and
// registered single-cycle rise/fall pulses.
module debounce_channel
    import paddle_input_conditioner_pkg::*;
#(
    parameter int unsigned DbCount = DbCountDefault,
    parameter int unsigned CntW    = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_raw_i,
    output logic db_level_o,
    output logic db_rise_o,
    output logic db_fall_o
);

    logic [1:0]      sync_q;
    logic            s;
    db_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            cnt_done;

    assign s        = sync_q[1];
    assign cnt_done = (cnt_q == CntW'(DbCount - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b00;
            state_q <= StLo;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], sw_raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Counter only runs in the waiting states, so it can never pass DbCount-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StLo: begin
                if (s) begin
                    state_d = StWhi;
                    cnt_d   = CntW'(1);
                end
            end
            StWhi: begin
                if (!s) begin
                    state_d = StLo;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = StHi;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHi: begin
                if (!s) begin
                    state_d = StWlo;
                    cnt_d   = CntW'(1);
                end
            end
            StWlo: begin
                if (s) begin
                    state_d = StHi;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = StLo;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    assign db_level_o = level_q;
    assign db_rise_o  = rise_q;
    assign db_fall_o  = fall_q;

endmodule

// File: rtl/paddle_input_conditioner.sv
// Two debounced paddle switches plus frame-aligned copies that only update on
// refr_tick, so paddle direction never changes mid-frame.
module paddle_input_conditioner
    import paddle_input_conditioner_pkg::*;
#(
    parameter int unsigned DbCount = DbCountDefault,
    parameter int unsigned CntW    = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       refr_tick_i,
    input  logic [1:0] sw_raw_i,
    output logic [1:0] db_level_o,
    output logic [1:0] db_rise_o,
    output logic [1:0] db_fall_o,
    output logic [1:0] incdec_o
);

    logic [1:0] incdec_q, incdec_d;

    for (genvar i = 0; i < 2; i++) begin : g_ch
        debounce_channel #(
            .DbCount(DbCount),
            .CntW   (CntW)
        ) u_channel (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .sw_raw_i  (sw_raw_i[i]),
            .db_level_o(db_level_o[i]),
            .db_rise_o (db_rise_o[i]),
            .db_fall_o (db_fall_o[i])
        );
    end

    // db_level_o is registered, so a coincident tick captures the pre-update level.
    always_comb begin
        incdec_d = incdec_q;
        if (refr_tick_i) begin
            incdec_d = db_level_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            incdec_q <= 2'b00;
        end else begin
            incdec_q <= incdec_d;
        end
    end

    assign incdec_o = incdec_q;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Directed bench for paddle_input_conditioner with a cycle-stamped scoreboard.
module tb_paddle_input_conditioner;
    import paddle_input_conditioner_pkg::*;

    logic       clk_i       = 1'b0;
    logic       rst_ni      = 1'b1;
    logic       refr_tick_i = 1'b0;
    logic [1:0] sw_raw_i    = 2'b00;
    logic [1:0] db_level_o;
    logic [1:0] db_rise_o;
    logic [1:0] db_fall_o;
    logic [1:0] incdec_o;

    paddle_input_conditioner #(
        .DbCount(DbCountSim),
        .CntW   (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .refr_tick_i(refr_tick_i),
        .sw_raw_i   (sw_raw_i),
        .db_level_o (db_level_o),
        .db_rise_o  (db_rise_o),
        .db_fall_o  (db_fall_o),
        .incdec_o   (incdec_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      tag;
        int         at;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] inc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic push(input string tag, input int ofs, input logic [1:0] lvl,
                        input logic [1:0] rise, input logic [1:0] fall, input logic [1:0] inc);
        exp_t e;
        e.tag  = tag;
        e.at   = cyc + ofs;
        e.lvl  = lvl;
        e.rise = rise;
        e.fall = fall;
        e.inc  = inc;
        sbq.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        logic [7:0] obs;
        logic [7:0] expv;
        obs  = {db_level_o, db_rise_o, db_fall_o, incdec_o};
        expv = {e.lvl, e.rise, e.fall, e.inc};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d lvl/rise/fall/inc observed=%b expected=%b",
                   e.tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
            if (sbq[i].at == cyc) begin
                compare(sbq[i]);
                sbq.delete(i);
            end
        end
    endtask

    task automatic now(input string tag, input logic [1:0] lvl, input logic [1:0] inc);
        exp_t e;
        e.tag  = tag;
        e.at   = cyc;
        e.lvl  = lvl;
        e.rise = 2'b00;
        e.fall = 2'b00;
        e.inc  = inc;
        compare(e);
    endtask

    task automatic hold(input string tag, input int n, input logic [1:0] lvl,
                        input logic [1:0] inc);
        repeat (n) begin
            push(tag, 1, lvl, 2'b00, 2'b00, inc);
            tick();
        end
    endtask

    initial begin
        // Reset and idle with both switches closed
        #2 rst_ni = 1'b0;
        sw_raw_i = 2'b11;
        hold("rst_hold", 5, 2'b00, 2'b00);
        now("rst_state", 2'b00, 2'b00);
        rst_ni = 1'b1;
        for (int k = 1; k <= 11; k++)
            push("release", k, (k >= 10) ? 2'b11 : 2'b00, (k == 10) ? 2'b11 : 2'b00,
                 2'b00, 2'b00);
        repeat (11) tick();
        push("refr_first", 1, 2'b11, 2'b00, 2'b00, 2'b11);
        refr_tick_i = 1'b1;
        tick();
        refr_tick_i = 1'b0;

        // Both switches released, then clean press on player 1
        sw_raw_i = 2'b00;
        for (int k = 1; k <= 11; k++)
            push("drop", k, (k >= 10) ? 2'b00 : 2'b11, 2'b00, (k == 10) ? 2'b11 : 2'b00,
                 2'b11);
        repeat (11) tick();
        push("refr_clear", 1, 2'b00, 2'b00, 2'b00, 2'b00);
        refr_tick_i = 1'b1;
        tick();
        refr_tick_i = 1'b0;
        sw_raw_i = 2'b01;
        for (int k = 1; k <= 20; k++)
            push("press", k, (k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00,
                 2'b00, 2'b00);
        repeat (20) tick();
        push("press_inc", 1, 2'b01, 2'b00, 2'b00, 2'b01);
        refr_tick_i = 1'b1;
        tick();
        refr_tick_i = 1'b0;
        hold("press_inc_hold", 2, 2'b01, 2'b01);

        // Bring player 1 low, then a bouncing input that must be ignored
        sw_raw_i = 2'b00;
        for (int k = 1; k <= 11; k++)
            push("lower0", k, (k >= 10) ? 2'b00 : 2'b01, 2'b00, (k == 10) ? 2'b01 : 2'b00,
                 2'b01);
        repeat (11) tick();
        sw_raw_i = 2'b01;
        hold("bounce", 3, 2'b00, 2'b01);
        sw_raw_i = 2'b00;
        hold("bounce", 3, 2'b00, 2'b01);
        sw_raw_i = 2'b01;
        hold("bounce", 3, 2'b00, 2'b01);
        sw_raw_i = 2'b00;
        hold("bounce_settle", 20, 2'b00, 2'b01);

        // Player 2: 7-cycle pulse rejected, 8-cycle pulse accepted for 8 cycles
        sw_raw_i = 2'b10;
        hold("glitch7", 7, 2'b00, 2'b01);
        sw_raw_i = 2'b00;
        hold("glitch7_after", 15, 2'b00, 2'b01);
        sw_raw_i = 2'b10;
        for (int k = 1; k <= 20; k++)
            push("pulse8", k, (k >= 10 && k <= 17) ? 2'b10 : 2'b00,
                 (k == 10) ? 2'b10 : 2'b00, (k == 18) ? 2'b10 : 2'b00, 2'b01);
        repeat (8) tick();
        sw_raw_i = 2'b00;
        repeat (12) tick();

        // Tick coinciding with the db_level rise captures the old level
        push("clr_inc", 1, 2'b00, 2'b00, 2'b00, 2'b00);
        refr_tick_i = 1'b1;
        tick();
        refr_tick_i = 1'b0;
        sw_raw_i = 2'b01;
        for (int k = 1; k <= 14; k++)
            push("coincide", k, (k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00,
                 2'b00, (k == 14) ? 2'b01 : 2'b00);
        repeat (9) tick();
        refr_tick_i = 1'b1;
        tick();
        refr_tick_i = 1'b0;
        repeat (3) tick();
        refr_tick_i = 1'b1;
        tick();
        refr_tick_i = 1'b0;

        // Reset in the middle of player 2's rising debounce
        sw_raw_i = 2'b11;
        hold("pre_midrst", 7, 2'b01, 2'b01);
        rst_ni = 1'b0;
        #1;
        now("midrst", 2'b00, 2'b00);
        hold("in_rst", 2, 2'b00, 2'b00);
        rst_ni = 1'b1;
        for (int k = 1; k <= 11; k++)
            push("rerelease", k, (k >= 10) ? 2'b11 : 2'b00, (k == 10) ? 2'b11 : 2'b00,
                 2'b00, 2'b00);
        repeat (11) tick();

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain observed=%0d pending expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
